raycast_nearest_hit: RTL and testbench

// - Per-ray closest-hit sequencer in front of the fixed-latency ray/shape intersect pipeline.
// - Accepts one ray (src, dir) and reads a runtime-sized shape table, one entry per cycle.
// - Issues one cast per shape, reduces the returned results to the nearest hit, emits one result per ray.
// - Sits between the ray generator and the shader; one ray in flight at a time.

---
 rtl/raycast_nearest_hit.sv | 251 +++++++++++++++++++++++++
 tb/tb_raycast_nearest_hit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raycast_nearest_hit.sv
// raycast_nearest_hit
//   Closest-hit sequencer for one ray at a time. It accepts a ray and walks a
//   shape table of runtime size, reading one entry per cycle. It issues one
//   cast per shape to a fixed-latency intersect pipeline. It reduces the
//   in-order results to the nearest hit and presents that hit to the consumer.
//
//   Optional feature macro: RAYCAST_NEAREST_NAN_FILTER_EN
//     When defined, a result with res_hit=1 counts as a miss if its squared
//     distance is NaN or +/-inf, or if its sign bit is set.
//     When undefined, res_hit is used as-is and the raw distance bits are compared.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        ray handshake; in_src/in_dir/num_shapes sampled on accept
//   shape_rd_en/addr/data    shape table read port, data valid one cycle after enable
//   cast_valid/src/dir/shape cast to the intersect pipeline (never stalls)
//   res_*                    pipeline results, one per cast, in issue order
//   out_valid/out_ready      nearest-hit result handshake
//   out_hit/shape_idx/sq_distance/intersection  nearest-hit payload
module raycast_nearest_hit #(
  parameter int unsigned MAX_SHAPES = 16,
  parameter int unsigned SHAPE_W    = 168,
  localparam int unsigned IDX_W     = (MAX_SHAPES > 1) ? $clog2(MAX_SHAPES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [47:0]        in_src,
  input  logic [47:0]        in_dir,
  input  logic [IDX_W:0]     num_shapes,
  output logic               shape_rd_en,
  output logic [IDX_W-1:0]   shape_rd_addr,
  input  logic [SHAPE_W-1:0] shape_rd_data,
  output logic               cast_valid,
  output logic [47:0]        cast_src,
  output logic [47:0]        cast_dir,
  output logic [SHAPE_W-1:0] cast_shape,
  input  logic               res_valid,
  input  logic               res_hit,
  input  logic [15:0]        res_sq_distance,
  input  logic [47:0]        res_intersection,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_shape_idx,
  output logic [15:0]        out_sq_distance,
  output logic [47:0]        out_intersection
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHAPES);
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               rd_en_q, rd_en_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               cast_valid_q, cast_valid_d;
  logic [47:0]        src_q, src_d;
  logic [47:0]        dir_q, dir_d;
  logic               best_hit_q, best_hit_d;
  logic [15:0]        best_dist_q, best_dist_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [47:0]        best_isect_q, best_isect_d;
  logic               out_valid_q, out_valid_d;
  logic               out_hit_q, out_hit_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [15:0]        out_dist_q, out_dist_d;
  logic [47:0]        out_isect_q, out_isect_d;

  logic               res_hit_eff;
  logic               res_better;
  logic               res_last;
  logic [CNT_W-1:0]   num_clamped;
  logic               cand_hit;
  logic [15:0]        cand_dist;
  logic [IDX_W-1:0]   cand_idx;
  logic [47:0]        cand_isect;

  // Hit qualification; bad distances are all encodings >= +inf once the sign is excluded.
`ifdef RAYCAST_NEAREST_NAN_FILTER_EN
  assign res_hit_eff = res_hit && !res_sq_distance[15] && (res_sq_distance[14:10] != 5'h1F);
`else
  assign res_hit_eff = res_hit;
`endif

  // Candidate best after folding in the current result; strict < keeps the lower index on ties.
  always_comb begin
    num_clamped = (num_shapes > MAX_CNT) ? MAX_CNT : num_shapes;
    res_better  = res_hit_eff && (!best_hit_q || (res_sq_distance < best_dist_q));
    res_last    = (res_cnt_q == (num_q - CNT_W'(1)));
    cand_hit    = res_better ? 1'b1 : best_hit_q;
    cand_dist   = res_better ? res_sq_distance : best_dist_q;
    cand_idx    = res_better ? res_cnt_q[IDX_W-1:0] : best_idx_q;
    cand_isect  = res_better ? res_intersection : best_isect_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    issue_cnt_d  = issue_cnt_q;
    res_cnt_d    = res_cnt_q;
    num_d        = num_q;
    cast_valid_d = rd_en_q;
    src_d        = src_q;
    dir_d        = dir_q;
    best_hit_d   = best_hit_q;
    best_dist_d  = best_dist_q;
    best_idx_d   = best_idx_q;
    best_isect_d = best_isect_q;
    out_valid_d  = out_valid_q;
    out_hit_d    = out_hit_q;
    out_idx_d    = out_idx_q;
    out_dist_d   = out_dist_q;
    out_isect_d  = out_isect_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          src_d        = in_src;
          dir_d        = in_dir;
          num_d        = num_clamped;
          issue_cnt_d  = '0;
          res_cnt_d    = '0;
          best_hit_d   = 1'b0;
          best_dist_d  = POS_INF;
          best_idx_d   = '0;
          best_isect_d = '0;
          if (num_clamped == '0) begin
            // Empty table: present a miss; out_valid rises one cycle into OUTPUT.
            state_d     = S_OUTPUT;
            out_hit_d   = 1'b0;
            out_idx_d   = '0;
            out_dist_d  = POS_INF;
            out_isect_d = '0;
          end else begin
            state_d = S_ISSUE;
            rd_en_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue_cnt_q == (num_q - CNT_W'(1))) begin
          state_d     = S_DRAIN;
          rd_en_d     = 1'b0;
          issue_cnt_d = '0;
        end else begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
      end
      S_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Result reduction overlaps issue; results outside ISSUE/DRAIN are ignored.
    if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && res_valid) begin
      best_hit_d   = cand_hit;
      best_dist_d  = cand_dist;
      best_idx_d   = cand_idx;
      best_isect_d = cand_isect;
      res_cnt_d    = res_cnt_q + CNT_W'(1);
      if (res_last) begin
        state_d     = S_OUTPUT;
        rd_en_d     = 1'b0;
        issue_cnt_d = '0;
        res_cnt_d   = '0;
        out_valid_d = 1'b1;
        out_hit_d   = cand_hit;
        out_idx_d   = cand_idx;
        out_dist_d  = cand_dist;
        out_isect_d = cand_isect;
      end
    end
  end

  // in_ready is registered, so it reflects the state being entered.
  assign in_ready_d = (state_d == S_IDLE);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      rd_en_q      <= 1'b0;
      issue_cnt_q  <= '0;
      res_cnt_q    <= '0;
      num_q        <= '0;
      cast_valid_q <= 1'b0;
      src_q        <= '0;
      dir_q        <= '0;
      best_hit_q   <= 1'b0;
      best_dist_q  <= POS_INF;
      best_idx_q   <= '0;
      best_isect_q <= '0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_idx_q    <= '0;
      out_dist_q   <= POS_INF;
      out_isect_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      rd_en_q      <= rd_en_d;
      issue_cnt_q  <= issue_cnt_d;
      res_cnt_q    <= res_cnt_d;
      num_q        <= num_d;
      cast_valid_q <= cast_valid_d;
      src_q        <= src_d;
      dir_q        <= dir_d;
      best_hit_q   <= best_hit_d;
      best_dist_q  <= best_dist_d;
      best_idx_q   <= best_idx_d;
      best_isect_q <= best_isect_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_idx_q    <= out_idx_d;
      out_dist_q   <= out_dist_d;
      out_isect_q  <= out_isect_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign shape_rd_en      = rd_en_q;
  assign shape_rd_addr    = issue_cnt_q[IDX_W-1:0];
  assign cast_valid       = cast_valid_q;
  assign cast_src         = src_q;
  assign cast_dir         = dir_q;
  // Table data arrives in the cycle cast_valid is high, so it is forwarded without a register.
  assign cast_shape       = shape_rd_data;
  assign out_valid        = out_valid_q;
  assign out_hit          = out_hit_q;
  assign out_shape_idx    = out_idx_q;
  assign out_sq_distance  = out_dist_q;
  assign out_intersection = out_isect_q;

endmodule

// File: tb/tb_raycast_nearest_hit.sv
// tb_raycast_nearest_hit
//   Self-checking bench for raycast_nearest_hit. It models the shape table and
//   a variable-latency intersect pipeline. Expected outputs are derived per ray
//   from a timeline (accept cycle, shape count, latency, consumer delay) and from
//   a min-distance search over the result table. A compare process checks every cycle.
module tb_raycast_nearest_hit;
  localparam int unsigned SW = 168;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [47:0]   in_src;
  logic [47:0]   in_dir;
  logic [4:0]    num_shapes;
  logic          shape_rd_en;
  logic [3:0]    shape_rd_addr;
  logic [SW-1:0] shape_rd_data;
  logic          cast_valid;
  logic [47:0]   cast_src;
  logic [47:0]   cast_dir;
  logic [SW-1:0] cast_shape;
  logic          res_valid;
  logic          res_hit;
  logic [15:0]   res_sq_distance;
  logic [47:0]   res_intersection;
  logic          out_valid;
  logic          out_ready;
  logic          out_hit;
  logic [3:0]    out_shape_idx;
  logic [15:0]   out_sq_distance;
  logic [47:0]   out_intersection;

  raycast_nearest_hit #(.MAX_SHAPES(16), .SHAPE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_dir(in_dir),
    .num_shapes(num_shapes),
    .shape_rd_en(shape_rd_en), .shape_rd_addr(shape_rd_addr), .shape_rd_data(shape_rd_data),
    .cast_valid(cast_valid), .cast_src(cast_src), .cast_dir(cast_dir), .cast_shape(cast_shape),
    .res_valid(res_valid), .res_hit(res_hit), .res_sq_distance(res_sq_distance),
    .res_intersection(res_intersection),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_shape_idx(out_shape_idx), .out_sq_distance(out_sq_distance),
    .out_intersection(out_intersection)
  );

  always #5 clk = ~clk;

  // Environment: shape table, per-shape results, intersect pipeline
  logic          hit_tab   [16];
  logic [15:0]   dist_tab  [16];
  logic [47:0]   isect_tab [16];
  logic [SW-1:0] mem       [16];
  logic [7:0]    pipe_v   = '0;
  logic [7:0]    res_seen = '0;
  int            lat      = 1;
  int            cyc      = 0;

  always @(posedge clk) begin
    pipe_v <= {pipe_v[6:0], cast_valid};
    if (in_valid && in_ready) res_seen <= '0;
    else if (res_valid)       res_seen <= res_seen + 8'd1;
    if (shape_rd_en) shape_rd_data <= mem[shape_rd_addr];
    cyc <= cyc + 1;
  end

  assign res_valid        = pipe_v[3'(lat - 1)];
  assign res_hit          = hit_tab[res_seen[3:0]];
  assign res_sq_distance  = dist_tab[res_seen[3:0]];
  assign res_intersection = isect_tab[res_seen[3:0]];

  // Expectation state for the current/last ray
  int          r_t = -1000, r_n = 0, r_l = 1, r_h = -1000;
  logic [47:0] e_src, e_dir, e_isect;
  logic        e_hit;
  logic [3:0]  e_idx;
  logic [15:0] e_dist;
  bit          chk_en = 1'b0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic eff(input int i);
`ifdef RAYCAST_NEAREST_NAN_FILTER_EN
    return hit_tab[i] && (dist_tab[i] < 16'h7C00);
`else
    return hit_tab[i];
`endif
  endfunction

  // Reference: smallest distance among qualifying hits, first index holding it.
  task automatic model(input int ne);
    logic        found;
    logic [15:0] mind;
    found = 1'b0;
    mind  = 16'hFFFF;
    for (int i = 0; i < ne; i++)
      if (eff(i)) begin
        found = 1'b1;
        if (dist_tab[i] < mind) mind = dist_tab[i];
      end
    e_hit = found; e_idx = '0; e_dist = 16'h7C00; e_isect = '0;
    if (found)
      for (int i = ne - 1; i >= 0; i--)
        if (eff(i) && dist_tab[i] == mind) begin
          e_idx = 4'(i); e_dist = dist_tab[i]; e_isect = isect_tab[i];
        end
  endtask

  // Per-cycle comparison against the timeline of the current ray
  always @(negedge clk) begin : compare
    int c, vs, si;
    bit act_w, rd_w, cv_w, ov_w;
    #1;
    if (chk_en) begin
      c     = cyc;
      vs    = r_t + 2 + r_n + ((r_n > 0) ? r_l : 0);
      act_w = (c >= r_t + 1) && (c <= r_h);
      rd_w  = (c >= r_t + 1) && (c <= r_t + r_n);
      cv_w  = (c >= r_t + 2) && (c <= r_t + 1 + r_n);
      ov_w  = (c >= vs) && (c <= r_h);
      chk("in_ready", 64'(in_ready), 64'(!act_w));
      chk("shape_rd_en", 64'(shape_rd_en), 64'(rd_w));
      if (rd_w) chk("shape_rd_addr", 64'(shape_rd_addr), 64'(c - r_t - 1));
      chk("cast_valid", 64'(cast_valid), 64'(cv_w));
      if (cv_w) begin
        si = c - r_t - 2;
        chk("cast_src", 64'(cast_src), 64'(e_src));
        chk("cast_dir", 64'(cast_dir), 64'(e_dir));
        n_chk++;
        if (cast_shape !== mem[4'(si)]) begin
          n_fail++;
          $display("FAIL cast_shape: got %h expected %h (cycle %0d)", cast_shape, mem[4'(si)], cyc);
        end
      end
      chk("out_valid", 64'(out_valid), 64'(ov_w));
      if (ov_w) begin
        chk("out_hit", 64'(out_hit), 64'(e_hit));
        chk("out_shape_idx", 64'(out_shape_idx), 64'(e_idx));
        chk("out_sq_distance", 64'(out_sq_distance), 64'(e_dist));
        chk("out_intersection", 64'(out_intersection), 64'(e_isect));
      end
    end
  end

  function automatic logic [15:0] pick_dist();
    case ($urandom_range(0, 7))
      0: return 16'h3C00;
      1: return 16'h4000;
      2: return 16'h4400;
      3: return 16'h0000;
      4: return 16'h7E00;
      5: return 16'h7C00;
      6: return 16'($urandom()) & 16'h7BFF;
      default: return 16'hC000;
    endcase
  endfunction

  task automatic rand_tables(input bit no_hits);
    for (int i = 0; i < 16; i++) begin
      hit_tab[i]   = no_hits ? 1'b0 : 1'($urandom_range(0, 1));
      dist_tab[i]  = pick_dist();
      isect_tab[i] = 48'({$urandom(), $urandom()});
      mem[i]       = SW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

  // Offer one ray; d = consumer delay after out_valid; abort>0 asserts rst that many cycles after accept.
  task automatic run_ray(input int n, input int l, input int d, input int abort);
    int ne;
    ne  = (n > 16) ? 16 : n;
    lat = l;
    model(ne);
    @(negedge clk);
    in_src     = 48'({$urandom(), $urandom()});
    in_dir     = 48'({$urandom(), $urandom()});
    in_valid   = 1'b1;
    num_shapes = 5'(n);
    out_ready  = (d == 0);
    e_src = in_src; e_dir = in_dir;
    r_n = ne; r_l = l;
    r_t = cyc;
    r_h = cyc + 2 + ne + ((ne > 0) ? l : 0) + d;
    @(negedge clk);
    in_valid   = 1'b0;
    in_src     = 48'({$urandom(), $urandom()});
    in_dir     = 48'({$urandom(), $urandom()});
    num_shapes = 5'($urandom_range(0, 16));
    if (abort > 0) begin
      while (cyc < r_t + abort) @(negedge clk);
      chk_en = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_shape_rd_en", 64'(shape_rd_en), 64'd0);
      chk("rst_cast_valid", 64'(cast_valid), 64'd0);
      rst = 1'b0;
      r_t = -1000; r_h = -1000;
      chk_en = 1'b1;
      repeat (l + 4) @(negedge clk);
    end else begin
      while (cyc < r_h) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_src = '0; in_dir = '0; num_shapes = '0; out_ready = 1'b0;
    rand_tables(1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_shape_rd_en", 64'(shape_rd_en), 64'd0);
    chk("reset_cast_valid", 64'(cast_valid), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_hit", 64'(out_hit), 64'd0);
    chk("reset_out_shape_idx", 64'(out_shape_idx), 64'd0);
    chk("reset_out_sq_distance", 64'(out_sq_distance), 64'h7C00);
    chk("reset_out_intersection", 64'(out_intersection), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // All miss
    rand_tables(1'b1);
    run_ray(3, 2, 0, 0);
    chk("miss_hit", 64'(out_hit), 64'd0);
    chk("miss_dist", 64'(out_sq_distance), 64'h7C00);
    chk("miss_idx", 64'(out_shape_idx), 64'd0);

    // Two hits, later one nearer
    rand_tables(1'b1);
    hit_tab[1] = 1'b1; dist_tab[1] = 16'h4400;
    hit_tab[3] = 1'b1; dist_tab[3] = 16'h3C00;
    run_ray(4, 3, 1, 0);
    chk("two_hit", 64'(out_hit), 64'd1);
    chk("two_idx", 64'(out_shape_idx), 64'd3);
    chk("two_dist", 64'(out_sq_distance), 64'h3C00);
    chk("two_isect", 64'(out_intersection), 64'(isect_tab[3]));

    // Tie keeps the lower index
    rand_tables(1'b1);
    hit_tab[0] = 1'b1; dist_tab[0] = 16'h4000;
    hit_tab[2] = 1'b1; dist_tab[2] = 16'h4000;
    run_ray(3, 1, 0, 0);
    chk("tie_idx", 64'(out_shape_idx), 64'd0);
    chk("tie_dist", 64'(out_sq_distance), 64'h4000);

    // Empty table
    rand_tables(1'b0);
    run_ray(0, 3, 0, 0);
    chk("zero_hit", 64'(out_hit), 64'd0);

    // Consumer holds off for 10 cycles
    rand_tables(1'b0);
    run_ray(5, 2, 10, 0);

    // Reset during drain, with late pipeline results arriving afterwards
    rand_tables(1'b0);
    run_ray(6, 4, 0, 8);
    chk("post_rst_hit", 64'(out_hit), 64'd0);
    chk("post_rst_dist", 64'(out_sq_distance), 64'h7C00);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Lone NaN hit
    rand_tables(1'b1);
    hit_tab[0] = 1'b1; dist_tab[0] = 16'h7E00;
    run_ray(1, 2, 0, 0);
`ifdef RAYCAST_NEAREST_NAN_FILTER_EN
    chk("nan_hit", 64'(out_hit), 64'd0);
`else
    chk("nan_hit", 64'(out_hit), 64'd1);
    chk("nan_dist", 64'(out_sq_distance), 64'h7E00);
`endif

    // Oversized count clamps to the table depth
    rand_tables(1'b0);
    run_ray(20, 2, 0, 0);

    // Randomized rays
    repeat (60) begin
      rand_tables(1'b0);
      run_ray(int'($urandom_range(0, 20)), int'($urandom_range(1, 6)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
